// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the sequential MixColumns engine: an input
// valid/ready channel carrying the state and mode, and an output
// valid/ready channel carrying the mixed state.
interface mix_columns_seq_if #(
   parameter int DATA_W = 128
);
   logic              in_valid;
   logic              in_ready;
   logic              in_mode;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport master (
      output in_valid,
      output in_mode,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_mode,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );
endinterface

// File: rtl/mix_columns_seq.sv
// Multi-cycle AES MixColumns / InvMixColumns engine. A block is captured
// in IDLE, mixed COLS_PER_CYC columns per clock in BUSY (lowest column
// first, in place), then presented in DONE until the downstream takes it.
module mix_columns_seq #(
   parameter int DATA_W       = 128,
   parameter int COLS_PER_CYC = 1
) (
   input logic              clk,
   input logic              rst,
   mix_columns_seq_if.slave bus
);
   localparam int NUM_COLS = DATA_W / 32;
   localparam int CNT_W    = $clog2(NUM_COLS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_COLS - COLS_PER_CYC);
   localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(COLS_PER_CYC);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mode_q, mode_d;
   logic [DATA_W-1:0] work_q, work_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [DATA_W-1:0] mixed;
   logic              in_ready;

   // Multiply by x in GF(2^8) modulo 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant using the 1x/2x/4x/8x xtime chain.
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [3:0] c);
      logic [7:0] x2, x4, x8;
      x2 = xtime(x);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (c[0] ? x  : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
             (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
   endfunction

   // One column through the forward or inverse coefficient matrix.
   // Row 0 sits in the top byte of the column word.
   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] r0, r1, r2, r3;
      {a0, a1, a2, a3} = col;
      if (inv) begin
         r0 = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
         r1 = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
         r2 = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
         r3 = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
      end else begin
         r0 = gf_mul(a0, 4'h2) ^ gf_mul(a1, 4'h3) ^ a2 ^ a3;
         r1 = a0 ^ gf_mul(a1, 4'h2) ^ gf_mul(a2, 4'h3) ^ a3;
         r2 = a0 ^ a1 ^ gf_mul(a2, 4'h2) ^ gf_mul(a3, 4'h3);
         r3 = gf_mul(a0, 4'h3) ^ a1 ^ a2 ^ gf_mul(a3, 4'h2);
      end
      return {r0, r1, r2, r3};
   endfunction

   // Work register with the current group of columns replaced by their mixed values.
   always_comb begin
      mixed = work_q;
      for (int k = 0; k < COLS_PER_CYC; k++) begin
         mixed[(int'(cnt_q) + k) * 32 +: 32] = mix_col(work_q[(int'(cnt_q) + k) * 32 +: 32], mode_q);
      end
   end

   // Next-state logic: capture in IDLE, mix in BUSY, hold result in DONE.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mode_d     = mode_q;
      work_d     = work_q;
      out_data_d = out_data_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready) begin
               work_d  = bus.in_data;
               mode_d  = bus.in_mode;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            work_d = mixed;
            if (cnt_q == LAST_CNT) begin
               cnt_d      = '0;
               out_data_d = mixed;
               state_d    = DONE;
            end else begin
               cnt_d = cnt_q + CNT_STEP;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset; reset abandons any block in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mode_q     <= 1'b0;
         work_q     <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         work_q     <= work_d;
         out_data_q <= out_data_d;
      end
   end

   assign in_ready      = (state_q == IDLE) && !rst;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: one instance per legal
// COLS_PER_CYC (1, 2, 4), known AES MixColumns vectors, handshake,
// backpressure, mid-block reset and mode latching scenarios.
module tb_mix_columns_seq;
   localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_d4bf5d30_01010101;
   localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_046681e5_01010101;
   localparam logic [127:0] ALL_C6  = {16{8'hc6}};

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   mix_columns_seq_if #(.DATA_W(128)) bus1 ();
   mix_columns_seq_if #(.DATA_W(128)) bus2 ();
   mix_columns_seq_if #(.DATA_W(128)) bus4 ();

   mix_columns_seq #(.DATA_W(128), .COLS_PER_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   mix_columns_seq #(.DATA_W(128), .COLS_PER_CYC(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
   mix_columns_seq #(.DATA_W(128), .COLS_PER_CYC(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Offers one block to dut1 from IDLE and waits (bounded) for out_valid.
   task automatic run_block(input logic [127:0] data, input logic mode,
                            output logic [127:0] result, output int lat);
      bus1.in_data  = data;
      bus1.in_mode  = mode;
      bus1.in_valid = 1'b1;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      lat = 0;
      while (bus1.out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      result = bus1.out_data;
   endtask

   // Takes the pending result from dut1 with a one-cycle out_ready pulse.
   task automatic finish_block;
      bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus1.in_valid = 0; bus1.in_mode = 0; bus1.in_data = '0; bus1.out_ready = 0;
      bus2.in_valid = 0; bus2.in_mode = 0; bus2.in_data = '0; bus2.out_ready = 0;
      bus4.in_valid = 0; bus4.in_mode = 0; bus4.in_data = '0; bus4.out_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus1.in_ready !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_in_ready got=%b want=0", bus1.in_ready);
      end
      checks++;
      if (bus1.out_valid !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_out_valid got=%b want=0", bus1.out_valid);
      end
      checks++;
      if (bus1.out_data !== 128'h0) begin
         failures++; $display("[TB] FAIL reset_out_data got=%h want=0", bus1.out_data);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({bus1.in_ready, bus2.in_ready, bus4.in_ready} !== 3'b111) begin
         failures++;
         $display("[TB] FAIL idle_in_ready got=%b%b%b want=111", bus1.in_ready, bus2.in_ready, bus4.in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_forward;
      logic [127:0] res;
      int           lat;
      run_block(FWD_IN, 1'b0, res, lat);
      checks++;
      if (res !== FWD_OUT) begin
         failures++; $display("[TB] FAIL fwd_data got=%h want=%h", res, FWD_OUT);
      end
      checks++;
      if (lat !== 4) begin
         failures++; $display("[TB] FAIL fwd_latency got=%0d want=4", lat);
      end
      checks++;
      if (bus1.in_ready !== 1'b0) begin
         failures++; $display("[TB] FAIL done_in_ready got=%b want=0", bus1.in_ready);
      end
      finish_block();
      checks++;
      if ({bus1.out_valid, bus1.in_ready} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL after_handshake got valid=%b ready=%b want valid=0 ready=1", bus1.out_valid, bus1.in_ready);
      end
   endtask

   task automatic test_inverse;
      logic [127:0] res;
      int           lat;
      run_block(FWD_OUT, 1'b1, res, lat);
      checks++;
      if (res !== FWD_IN) begin
         failures++; $display("[TB] FAIL inv_data got=%h want=%h", res, FWD_IN);
      end
      checks++;
      if (lat !== 4) begin
         failures++; $display("[TB] FAIL inv_latency got=%0d want=4", lat);
      end
      finish_block();
   endtask

   task automatic test_fixed_point;
      logic [127:0] res;
      int           lat;
      for (int m = 0; m < 2; m++) begin
         run_block(ALL_C6, m[0], res, lat);
         checks++;
         if (res !== ALL_C6) begin
            failures++; $display("[TB] FAIL fixed_c6_mode%0d got=%h want=%h", m, res, ALL_C6);
         end
         checks++;
         if (lat !== 4) begin
            failures++; $display("[TB] FAIL fixed_c6_latency_mode%0d got=%0d want=4", m, lat);
         end
         finish_block();
      end
   endtask

   task automatic test_mode_latch;
      int lat;
      bus1.in_data  = FWD_IN;
      bus1.in_mode  = 1'b0;
      bus1.in_valid = 1'b1;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      lat = 0;
      while (bus1.out_valid !== 1'b1 && lat < 20) begin
         bus1.in_mode = ~bus1.in_mode;
         bus1.in_data = ~bus1.in_data;
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (bus1.out_data !== FWD_OUT) begin
         failures++; $display("[TB] FAIL mode_latch_data got=%h want=%h", bus1.out_data, FWD_OUT);
      end
      checks++;
      if (lat !== 4) begin
         failures++; $display("[TB] FAIL mode_latch_latency got=%0d want=4", lat);
      end
      bus1.in_mode = 1'b0;
      finish_block();
   endtask

   task automatic test_back_to_back;
      logic [127:0] res;
      int           lat;
      run_block(FWD_IN, 1'b0, res, lat);
      checks++;
      if (res !== FWD_OUT) begin
         failures++; $display("[TB] FAIL bp_first_data got=%h want=%h", res, FWD_OUT);
      end
      bus1.in_data  = FWD_OUT;
      bus1.in_mode  = 1'b1;
      bus1.in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checks++;
         if (bus1.out_data !== FWD_OUT || bus1.in_ready !== 1'b0 || bus1.out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_hold_cycle%0d got data=%h ready=%b valid=%b want data=%h ready=0 valid=1",
                     c, bus1.out_data, bus1.in_ready, bus1.out_valid, FWD_OUT);
         end
      end
      bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.out_ready = 1'b0;
      checks++;
      if ({bus1.out_valid, bus1.in_ready} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", bus1.out_valid, bus1.in_ready);
      end
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      checks++;
      if (bus1.in_ready !== 1'b0) begin
         failures++; $display("[TB] FAIL bp_second_accept got ready=%b want=0", bus1.in_ready);
      end
      lat = 0;
      while (bus1.out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (bus1.out_data !== FWD_IN) begin
         failures++; $display("[TB] FAIL bp_second_data got=%h want=%h", bus1.out_data, FWD_IN);
      end
      checks++;
      if (lat !== 4) begin
         failures++; $display("[TB] FAIL bp_second_latency got=%0d want=4", lat);
      end
      finish_block();
   endtask

   task automatic test_reset_mid_busy;
      logic [127:0] res;
      int           lat;
      int           seen;
      bus1.in_data  = FWD_IN;
      bus1.in_mode  = 1'b0;
      bus1.in_valid = 1'b1;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus1.out_valid !== 1'b0) begin
         failures++; $display("[TB] FAIL midrst_out_valid got=%b want=0", bus1.out_valid);
      end
      checks++;
      if (bus1.out_data !== 128'h0) begin
         failures++; $display("[TB] FAIL midrst_out_data got=%h want=0", bus1.out_data);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus1.in_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL midrst_idle got ready=%b want=1", bus1.in_ready);
      end
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (bus1.out_valid === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++; $display("[TB] FAIL midrst_no_pulse got=%0d valid cycles want=0", seen);
      end
      run_block(FWD_IN, 1'b0, res, lat);
      checks++;
      if (res !== FWD_OUT || lat !== 4) begin
         failures++; $display("[TB] FAIL midrst_fresh got=%h lat=%0d want=%h lat=4", res, lat, FWD_OUT);
      end
      finish_block();
   endtask

   task automatic test_wide_builds;
      logic [127:0] vin  [2];
      logic [127:0] vout [2];
      logic [127:0] res2, res4;
      int           lat2, lat4;
      vin[0] = FWD_IN;  vout[0] = FWD_OUT;
      vin[1] = FWD_OUT; vout[1] = FWD_IN;
      for (int m = 0; m < 2; m++) begin
         bus2.in_data = vin[m]; bus2.in_mode = m[0]; bus2.in_valid = 1'b1;
         bus4.in_data = vin[m]; bus4.in_mode = m[0]; bus4.in_valid = 1'b1;
         @(posedge clk); #1;
         bus2.in_valid = 1'b0;
         bus4.in_valid = 1'b0;
         lat2 = -1; lat4 = -1; res2 = '0; res4 = '0;
         for (int n = 1; n <= 20 && (lat2 < 0 || lat4 < 0); n++) begin
            @(posedge clk); #1;
            if (lat2 < 0 && bus2.out_valid === 1'b1) begin lat2 = n; res2 = bus2.out_data; end
            if (lat4 < 0 && bus4.out_valid === 1'b1) begin lat4 = n; res4 = bus4.out_data; end
         end
         checks++;
         if (res2 !== vout[m]) begin
            failures++; $display("[TB] FAIL cpc2_mode%0d_data got=%h want=%h", m, res2, vout[m]);
         end
         checks++;
         if (lat2 !== 2) begin
            failures++; $display("[TB] FAIL cpc2_mode%0d_latency got=%0d want=2", m, lat2);
         end
         checks++;
         if (res4 !== vout[m]) begin
            failures++; $display("[TB] FAIL cpc4_mode%0d_data got=%h want=%h", m, res4, vout[m]);
         end
         checks++;
         if (lat4 !== 1) begin
            failures++; $display("[TB] FAIL cpc4_mode%0d_latency got=%0d want=1", m, lat4);
         end
         bus2.out_ready = 1'b1;
         bus4.out_ready = 1'b1;
         @(posedge clk); #1;
         bus2.out_ready = 1'b0;
         bus4.out_ready = 1'b0;
      end
   endtask

   // Runs every scenario in order and prints the summary.
   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_forward();
      test_inverse();
      test_fixed_point();
      test_mode_latch();
      test_back_to_back();
      test_reset_mid_busy();
      test_wide_builds();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
